// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video has absolute priority, CPU and DMA share leftover slots round-robin.
// Registered VRAM command stage, 2-stage read tag pipe, per-requester starvation watchdog.
module vram_arbiter #(
  parameter int unsigned AW         = 15,
  parameter int unsigned DW         = 8,
  parameter int unsigned STARVE_LIM = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_rvalid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic          cpu_ack,
  output logic          cpu_rvalid,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_din,
  output logic          dma_ack,
  output logic          dma_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic [1:0]    starve,
  input  logic          starve_clr
);

  localparam int unsigned CW = 7;
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_DMA  = 2'd3
  } owner_t;

  logic          last;
  logic          grant_vid;
  logic          grant_cpu;
  logic          grant_dma;
  logic [AW-1:0] addr_nxt;
  logic          we_nxt;
  logic [DW-1:0] din_nxt;
  owner_t        own_nxt;
  logic          rd_nxt;
  owner_t        own_q;
  logic          rd_q;
  logic [1:0][CW-1:0] wait_cnt;
  logic [1:0]    pend;
  logic [1:0]    acked;
  logic [1:0]    hit;

  // Grant decision; last = 1 means DMA was served last, so CPU wins the tie
  always_comb begin
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    if (!reset) begin
      if (vid_req) begin
        grant_vid = 1'b1;
      end else if (cpu_req && dma_req) begin
        grant_cpu = last;
        grant_dma = !last;
      end else begin
        grant_cpu = cpu_req;
        grant_dma = dma_req;
      end
    end
  end

  assign cpu_ack = grant_cpu;
  assign dma_ack = grant_dma;
  assign rdata   = mem_dout;

  // Command mux; address and data hold when the port is idle
  always_comb begin
    addr_nxt = mem_addr;
    we_nxt   = 1'b0;
    din_nxt  = mem_din;
    own_nxt  = OWN_NONE;
    rd_nxt   = 1'b0;
    if (grant_vid) begin
      addr_nxt = vid_addr;
      own_nxt  = OWN_VID;
      rd_nxt   = 1'b1;
    end else if (grant_cpu) begin
      addr_nxt = cpu_addr;
      we_nxt   = cpu_we;
      din_nxt  = cpu_din;
      own_nxt  = OWN_CPU;
      rd_nxt   = !cpu_we;
    end else if (grant_dma) begin
      addr_nxt = dma_addr;
      we_nxt   = dma_we;
      din_nxt  = dma_din;
      own_nxt  = OWN_DMA;
      rd_nxt   = !dma_we;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_din    <= '0;
      own_q      <= OWN_NONE;
      rd_q       <= 1'b0;
      vid_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      last       <= 1'b1;
    end else begin
      mem_addr   <= addr_nxt;
      mem_we     <= we_nxt;
      mem_din    <= din_nxt;
      own_q      <= own_nxt;
      rd_q       <= rd_nxt;
      vid_rvalid <= rd_q && (own_q == OWN_VID);
      cpu_rvalid <= rd_q && (own_q == OWN_CPU);
      dma_rvalid <= rd_q && (own_q == OWN_DMA);
      if (grant_cpu) begin
        last <= 1'b0;
      end else if (grant_dma) begin
        last <= 1'b1;
      end
    end
  end

  // Starvation watchdog: index 0 = CPU, 1 = DMA; flag sets on the cycle the count reaches the limit
  assign pend  = {dma_req, cpu_req};
  assign acked = {grant_dma, grant_cpu};

  always_comb begin
    hit = '0;
    for (int i = 0; i < 2; i++) begin
      hit[i] = pend[i] && !acked[i] && (wait_cnt[i] != '1) &&
               ((wait_cnt[i] + CW'(1)) == LIM);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      starve   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] || acked[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != '1) begin
          wait_cnt[i] <= wait_cnt[i] + CW'(1);
        end
        if (hit[i]) begin
          starve[i] <= 1'b1;
        end else if (starve_clr) begin
          starve[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed vectors and corner sequences, then random traffic against
// a transaction-level model (priority rules, serialized memory image, expected-return pipeline).
`timescale 1ns/1ps
module tb_vram_arbiter;

  localparam int unsigned AW  = 15;
  localparam int unsigned DW  = 8;
  localparam int          LIM = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_rvalid;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic          cpu_ack, cpu_rvalid;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_din;
  logic          dma_ack, dma_rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic [1:0]    starve;
  logic          starve_clr;

  vram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(LIM)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rvalid(vid_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
    .dma_ack(dma_ack), .dma_rvalid(dma_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dout(mem_dout), .starve(starve), .starve_clr(starve_clr)
  );

  always #5 clk = ~clk;

  // Synchronous VRAM: read data one cycle after the address
  logic [DW-1:0] ram       [0:(1<<AW)-1];
  logic [DW-1:0] model_ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a * 7 + 3);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    vid_req = 0; vid_addr = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_din = '0;
    starve_clr = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    cyc();
    cyc();
    reset = 0;
  endtask

  typedef struct {
    logic vid, cpu, dma;
    logic cack, dack;
  } vec_t;
  vec_t vecs[10];

  // Random-phase model state
  int            g, prev_g, vid_hold;
  int            m_last;
  logic [AW-1:0] exp_addr;
  logic          exp_we;
  logic [DW-1:0] exp_din;
  int            p1_own, p2_own;
  logic          p1_rd, p2_rd;
  logic [DW-1:0] p1_data, p2_data;
  int            w_cpu, w_dma;
  logic [1:0]    exp_starve;
  logic          set_c, set_d, rd_now;
  logic [AW-1:0] g_addr;

  initial begin
    // Sequential vectors from reset: {vid,cpu,dma} -> {cpu_ack,dma_ack}
    vecs[0] = '{1, 1, 1, 0, 0};
    vecs[1] = '{0, 1, 1, 1, 0};
    vecs[2] = '{0, 1, 1, 0, 1};
    vecs[3] = '{0, 1, 0, 1, 0};
    vecs[4] = '{0, 1, 0, 1, 0};
    vecs[5] = '{0, 0, 1, 0, 1};
    vecs[6] = '{0, 1, 1, 1, 0};
    vecs[7] = '{1, 0, 1, 0, 0};
    vecs[8] = '{0, 0, 0, 0, 0};
    vecs[9] = '{0, 1, 1, 0, 1};

    for (int i = 0; i < (1 << AW); i++) ram[i] = init_val(i);

    do_reset();
    settle();
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_rvalid", {vid_rvalid, cpu_rvalid, dma_rvalid}, 0);
    chk("rst_starve", starve, 0);

    // Video-only read
    vid_req = 1; vid_addr = 15'h0010;
    cyc();
    vid_req = 0;
    settle();
    chk("vid_mem_addr", mem_addr, 15'h0010);
    chk("vid_mem_we", mem_we, 0);
    cyc(); settle();
    chk("vid_rvalid", vid_rvalid, 1);
    chk("vid_rdata", rdata, init_val(16));
    chk("vid_cpu_rvalid", cpu_rvalid, 0);
    cyc(); settle();
    chk("vid_rvalid_once", vid_rvalid, 0);

    // CPU write then read back
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 15'h1234; cpu_din = 8'hA5;
    settle();
    chk("cw_ack", cpu_ack, 1);
    cyc();
    cpu_we = 0;
    settle();
    chk("cr_ack", cpu_ack, 1);
    chk("cw_mem_we", mem_we, 1);
    chk("cw_mem_addr", mem_addr, 15'h1234);
    chk("cw_mem_din", mem_din, 8'hA5);
    cyc();
    cpu_req = 0;
    settle();
    chk("cr_mem_we", mem_we, 0);
    chk("cw_no_rvalid", cpu_rvalid, 0);
    cyc(); settle();
    chk("cr_rvalid", cpu_rvalid, 1);
    chk("cr_rdata", rdata, 8'hA5);
    cyc(); settle();
    chk("cr_rvalid_once", cpu_rvalid, 0);

    // CPU/DMA tie after reset alternates, CPU first
    do_reset();
    cpu_req = 1; cpu_addr = 15'h0100;
    dma_req = 1; dma_addr = 15'h0200;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("tie_cpu_ack", cpu_ack, (k % 2 == 0));
      chk("tie_dma_ack", dma_ack, (k % 2 == 1));
      if (k >= 2) begin
        chk("tie_cpu_rvalid", cpu_rvalid, (k % 2 == 0));
        chk("tie_dma_rvalid", dma_rvalid, (k % 2 == 1));
        chk("tie_rdata", rdata, (k % 2 == 0) ? init_val(16'h100) : init_val(16'h200));
      end
      cyc();
    end
    idle_inputs();

    // Table-driven grant vectors
    do_reset();
    for (int i = 0; i < 10; i++) begin
      vid_req = vecs[i].vid; cpu_req = vecs[i].cpu; dma_req = vecs[i].dma;
      cpu_addr = AW'(i); dma_addr = AW'(i + 100);
      settle();
      chk("vec_cpu_ack", cpu_ack, vecs[i].cack);
      chk("vec_dma_ack", dma_ack, vecs[i].dack);
      cyc();
    end
    idle_inputs();

    // Video preempts a pending CPU request for 10 cycles
    do_reset();
    vid_req = 1; vid_addr = 15'h0020; cpu_req = 1; cpu_addr = 15'h0030;
    for (int k = 0; k < 10; k++) begin
      settle();
      chk("pre_cpu_blocked", cpu_ack, 0);
      cyc();
    end
    vid_req = 0;
    settle();
    chk("pre_cpu_ack", cpu_ack, 1);
    chk("pre_starve", starve, 0);
    cyc();
    idle_inputs();

    // Starvation under a 70-cycle video burst
    do_reset();
    vid_req = 1; cpu_req = 1; cpu_addr = 15'h0040;
    for (int k = 0; k < 70; k++) begin
      settle();
      if (k == 63) chk("stv_before", starve, 2'b00);
      if (k == 64) chk("stv_set", starve, 2'b01);
      cyc();
    end
    vid_req = 0;
    settle();
    chk("stv_ack", cpu_ack, 1);
    chk("stv_sticky", starve, 2'b01);
    cyc();
    cpu_req = 0; starve_clr = 1;
    settle();
    chk("stv_hold", starve, 2'b01);
    cyc();
    starve_clr = 0;
    settle();
    chk("stv_clr", starve, 2'b00);
    cyc();

    // Reset one cycle after a CPU read ack drops the read and re-arms CPU-first
    do_reset();
    cpu_req = 1; cpu_addr = 15'h0055;
    settle();
    chk("rmr_ack", cpu_ack, 1);
    cyc();
    reset = 1; dma_req = 1;
    settle();
    chk("rmr_mem_we", mem_we, 0);
    chk("rmr_mem_addr", mem_addr, 0);
    chk("rmr_ack_in_reset", {cpu_ack, dma_ack}, 2'b00);
    chk("rmr_rvalid0", cpu_rvalid, 0);
    cyc(); settle();
    chk("rmr_rvalid1", cpu_rvalid, 0);
    chk("rmr_ack_in_reset2", {cpu_ack, dma_ack}, 2'b00);
    cyc();
    reset = 0;
    settle();
    chk("rmr_tie_cpu", cpu_ack, 1);
    chk("rmr_tie_dma", dma_ack, 0);
    chk("rmr_rvalid2", cpu_rvalid, 0);
    cyc(); settle();
    chk("rmr_rvalid3", cpu_rvalid, 0);
    cyc();

    // Random traffic against the reference model
    do_reset();
    for (int i = 0; i < (1 << AW); i++) model_ram[i] = ram[i];
    m_last = 1; exp_addr = '0; exp_we = 0; exp_din = '0;
    p1_own = 0; p2_own = 0; p1_rd = 0; p2_rd = 0; p1_data = '0; p2_data = '0;
    w_cpu = 0; w_dma = 0; exp_starve = '0; prev_g = 0; vid_hold = 0;

    for (int n = 0; n < 3000; n++) begin
      if (vid_hold > 0) begin
        vid_req = 1; vid_hold--;
      end else begin
        vid_req = ($urandom_range(0, 99) < 25);
        if ($urandom_range(0, 399) == 0) vid_hold = 80;
      end
      vid_addr = AW'($urandom_range(0, 31));
      if (!cpu_req || prev_g == 2) begin
        cpu_req = ($urandom_range(0, 99) < 50);
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = AW'($urandom_range(0, 31));
        cpu_din = DW'($urandom);
      end else if ($urandom_range(0, 99) < 2) cpu_req = 0;
      if (!dma_req || prev_g == 3) begin
        dma_req = ($urandom_range(0, 99) < 50);
        dma_we = 1'($urandom_range(0, 1));
        dma_addr = AW'($urandom_range(0, 31));
        dma_din = DW'($urandom);
      end else if ($urandom_range(0, 99) < 2) dma_req = 0;
      starve_clr = ($urandom_range(0, 99) < 3);
      settle();

      chk("rnd_vid_rvalid", vid_rvalid, p2_rd && p2_own == 1);
      chk("rnd_cpu_rvalid", cpu_rvalid, p2_rd && p2_own == 2);
      chk("rnd_dma_rvalid", dma_rvalid, p2_rd && p2_own == 3);
      if (p2_rd) chk("rnd_rdata", rdata, p2_data);
      chk("rnd_mem_addr", mem_addr, exp_addr);
      chk("rnd_mem_we", mem_we, exp_we);
      chk("rnd_mem_din", mem_din, exp_din);
      chk("rnd_starve", starve, exp_starve);

      // 0 none, 1 video, 2 cpu, 3 dma
      if (vid_req) g = 1;
      else if (cpu_req && dma_req) g = (m_last == 1) ? 2 : 3;
      else if (cpu_req) g = 2;
      else if (dma_req) g = 3;
      else g = 0;
      chk("rnd_cpu_ack", cpu_ack, g == 2);
      chk("rnd_dma_ack", dma_ack, g == 3);

      p2_own = p1_own; p2_rd = p1_rd; p2_data = p1_data;
      rd_now = (g == 1) || (g == 2 && !cpu_we) || (g == 3 && !dma_we);
      g_addr = (g == 1) ? vid_addr : (g == 2) ? cpu_addr : dma_addr;
      p1_own = g; p1_rd = rd_now;
      p1_data = (g != 0) ? model_ram[g_addr] : '0;
      exp_we = (g == 2 && cpu_we) || (g == 3 && dma_we);
      if (g != 0) exp_addr = g_addr;
      if (g == 2) exp_din = cpu_din;
      if (g == 3) exp_din = dma_din;
      if (exp_we) model_ram[g_addr] = exp_din;
      if (g == 2) m_last = 0;
      if (g == 3) m_last = 1;

      set_c = 0; set_d = 0;
      if (cpu_req && g != 2) begin
        if (w_cpu < 127) begin w_cpu++; set_c = (w_cpu == LIM); end
      end else w_cpu = 0;
      if (dma_req && g != 3) begin
        if (w_dma < 127) begin w_dma++; set_d = (w_dma == LIM); end
      end else w_dma = 0;
      exp_starve[0] = set_c ? 1'b1 : (starve_clr ? 1'b0 : exp_starve[0]);
      exp_starve[1] = set_d ? 1'b1 : (starve_clr ? 1'b0 : exp_starve[1]);

      prev_g = g;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
